bp_me_cache_pkt_arbiter: RTL and testbench
==========================================

// Module: bp_me_cache_pkt_arbiter
// PURPOSE
//  Shares one bsg_cache packet port between num_req_p cce-to-cache requesters.
//  - Arbitration: round-robin, with a lock that holds the grant across a multi-packet stream.
//  - Response routing: bsg_cache returns data in order, so a FIFO of owner IDs sends each response back to its issuing requester.
// PARAMETERS
//  num_req_p      2    number of requesters (>=2)
//  pkt_width_p    118  bsg_cache_pkt width (paddr 40, data 64)
//  data_width_p   64   cache response data width
//  els_p          4    max outstanding packets tracked (>=2)
// PORTS
//  clk_i          in   1                       clock
//  reset_i        in   1                       async active-high reset
//  pkt_i          in   num_req_p*pkt_width_p   per-requester cache packet
//  pkt_v_i        in   num_req_p               packet valid
//  pkt_lock_i     in   num_req_p               keep grant for this requester's next packet
//  pkt_yumi_o     out  num_req_p               packet accepted (one-hot or zero)
//  data_o         out  data_width_p            response data, shared by all requesters
//  data_v_o       out  num_req_p               response valid (one-hot or zero)
//  data_yumi_i    in   num_req_p               response consumed
//  cache_pkt_o    out  pkt_width_p             packet to cache
//  cache_pkt_v_o  out  1                       packet valid to cache
//  cache_pkt_ready_i in 1                      cache can accept a packet
//  cache_data_i   in   data_width_p            cache response data
//  cache_v_i      in   1                       cache response valid
//  cache_yumi_o   out  1                       cache response consumed
//  err_o          out  1                       sticky: cache_v_i seen with no outstanding owner
// BEHAVIOUR
//  Reset
//  - Asynchronous; takes effect immediately, not at a clock edge.
//  - State after reset: rr_r=0, locked_r=0, owner_r=0, FIFO empty (cnt_r=0), err_o=0.
//  - Every output is 0 during reset.
//  - Reset mid-stream or mid-lock discards all tracking; the cache shares reset_i.
//  Issue (single-cycle, combinational)
//  - can_issue = cache_pkt_ready_i & (cnt_r < els_p).
//  - Unlocked: grant the first r with pkt_v_i[r]=1, searching from rr_r upward and wrapping mod num_req_p.
//  - Locked: only owner_r is eligible. Other requesters get no yumi even if the owner is idle.
//  - On grant g (when can_issue=1): cache_pkt_v_o=1, cache_pkt_o=pkt_i[g], pkt_yumi_o[g]=1, owner ID g pushed into the FIFO.
//  - Next rr_r = (g+1) mod num_req_p. This rule applies to locked grants too.
//  - pkt_lock_i[g]=1 on a granted packet: locked_r<=1, owner_r<=g. pkt_lock_i[g]=0: locked_r<=0.
//  - pkt_lock_i is sampled only on a granted cycle.
//  - cache_pkt_v_o is never 1 while cache_pkt_ready_i=0 (ready-then-valid).
//  - No grant: cache_pkt_o=0, rr_r and lock state hold.
//  Response routing
//  - head = FIFO head. data_o=cache_data_i.
//  - data_v_o[head] = cache_v_i & (cnt_r!=0); all other data_v_o bits are 0.
//  - cache_yumi_o = data_v_o[head] & data_yumi_i[head]; a set cache_yumi_o pops the FIFO.
//  - data_yumi_i bits not matching the head are ignored.
//  Counter
//  - cnt_r is clog2(els_p+1) bits: cnt_r <= cnt_r + push - pop.
//  - Push and pop in the same cycle leaves cnt_r unchanged.
//  - Full: issue uses the registered cnt_r, so a pop in the full cycle frees a slot for the next cycle, not the same cycle.
//  - FIFO read/write pointers wrap mod els_p.
//  Error
//  - cache_v_i=1 while cnt_r=0 sets err_o sticky until reset.
//  - In that case nothing is routed and cache_yumi_o=0.
//  Latency
//  - Issue path: 0 cycles, combinational requester -> cache.
//  - Response path: 0 cycles, combinational cache -> requester.
//  - No added pipeline stages.
// TESTING
//  1 Req0 sends 3 pkts, ready=1, cache returns 0xA,0xB,0xC -> issued on 3 consecutive cycles; data_v_o=2'b01 each time; cnt_r returns to 0.
//  2 Both requesters valid for 6 cycles, no lock, ready=1, responses drained -> grant order 0,1,0,1,0,1; responses routed in the same order.
//  3 Req1 holds lock for 8 pkts (lock=0 on the 8th) while req0 valid -> 8 consecutive grants to req1, then req0 granted on the next cycle.
//  4 els_p=4, cache_v_i=0, 5 pkts offered -> 4 issued, then pkt_yumi_o=0; one response popped at cycle t -> 5th issued at t+1.
//  5 cache_pkt_ready_i=0 with pkt_v_i=2'b11 -> cache_pkt_v_o=0, pkt_yumi_o=0, rr_r unchanged; ready=1 -> req rr_r granted.
//  6 cache_v_i=1 with FIFO empty -> err_o=1, data_v_o=0, cache_yumi_o=0; async reset mid-lock -> all outputs 0 at once, locked_r=0.

Source files
------------

// File: rtl/bp_me_cache_pkt_arbiter.sv
// Round-robin arbiter that lets num_req_p requesters share one bsg_cache packet port.
// A FIFO of owner IDs routes the in-order cache responses back to their issuers.
module bp_me_cache_pkt_arbiter #(
  parameter int num_req_p    = 2,
  parameter int pkt_width_p  = 118,
  parameter int data_width_p = 64,
  parameter int els_p        = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*pkt_width_p-1:0] pkt_i,
  input  logic [num_req_p-1:0]             pkt_v_i,
  input  logic [num_req_p-1:0]             pkt_lock_i,
  output logic [num_req_p-1:0]             pkt_yumi_o,
  output logic [data_width_p-1:0]          data_o,
  output logic [num_req_p-1:0]             data_v_o,
  input  logic [num_req_p-1:0]             data_yumi_i,
  output logic [pkt_width_p-1:0]           cache_pkt_o,
  output logic                             cache_pkt_v_o,
  input  logic                             cache_pkt_ready_i,
  input  logic [data_width_p-1:0]          cache_data_i,
  input  logic                             cache_v_i,
  output logic                             cache_yumi_o,
  output logic                             err_o
);

  localparam int id_w  = $clog2(num_req_p);
  localparam int cnt_w = $clog2(els_p + 1);
  localparam int ptr_w = $clog2(els_p);

  logic [id_w-1:0]  rr_r;
  logic             locked_r;
  logic [id_w-1:0]  owner_r;
  logic [id_w-1:0]  owner_mem [els_p];
  logic [ptr_w-1:0] wptr_r;
  logic [ptr_w-1:0] rptr_r;
  logic [cnt_w-1:0] cnt_r;
  logic             err_r;

  logic             grant_v;
  logic [id_w-1:0]  grant_id;
  logic [id_w-1:0]  scan_idx;
  logic [id_w-1:0]  rr_next;
  logic [id_w-1:0]  head;
  logic             issue;
  logic             resp_v;
  logic             pop;

  // Scan downward from the farthest offset so the requester nearest rr_r wins last.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    scan_idx = '0;
    if (locked_r) begin
      grant_v  = pkt_v_i[owner_r];
      grant_id = owner_r;
    end else begin
      for (int i = num_req_p - 1; i >= 0; i--) begin
        scan_idx = id_w'((int'(rr_r) + i) % num_req_p);
        if (pkt_v_i[scan_idx]) begin
          grant_v  = 1'b1;
          grant_id = scan_idx;
        end
      end
    end
  end

  // Handshakes: a requester packet transfers when pkt_yumi_o is set (ready-then-valid
  // toward the cache, so cache_pkt_v_o only rises while cache_pkt_ready_i is high);
  // a response transfers when data_v_o and data_yumi_i are both set for the head owner.
  assign issue   = grant_v & cache_pkt_ready_i & (cnt_r < cnt_w'(els_p)) & ~reset_i;
  assign rr_next = (grant_id == id_w'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
  assign head    = owner_mem[rptr_r];
  assign resp_v  = cache_v_i & (cnt_r != '0) & ~reset_i;
  assign pop     = resp_v & data_yumi_i[head];

  always_comb begin
    pkt_yumi_o  = '0;
    cache_pkt_o = '0;
    data_v_o    = '0;
    if (issue) begin
      pkt_yumi_o[grant_id] = 1'b1;
      cache_pkt_o          = pkt_i[grant_id*pkt_width_p +: pkt_width_p];
    end
    data_v_o[head] = resp_v;
  end

  assign cache_pkt_v_o = issue;
  assign cache_yumi_o  = pop;
  assign data_o        = reset_i ? '0 : cache_data_i;
  assign err_o         = err_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_r     <= '0;
      locked_r <= 1'b0;
      owner_r  <= '0;
      wptr_r   <= '0;
      rptr_r   <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      if (issue) begin
        rr_r     <= rr_next;
        locked_r <= pkt_lock_i[grant_id];
        owner_r  <= grant_id;
        wptr_r   <= (wptr_r == ptr_w'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      end
      if (pop) begin
        rptr_r <= (rptr_r == ptr_w'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      end
      cnt_r <= cnt_r + cnt_w'(issue) - cnt_w'(pop);
      if (cache_v_i && (cnt_r == '0)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Owner storage needs no reset: entries are only read while cnt_r is non-zero.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      owner_mem[wptr_r] <= grant_id;
    end
  end

endmodule

// File: tb/tb_bp_me_cache_pkt_arbiter.sv
// Bench for bp_me_cache_pkt_arbiter: directed scenario tables plus random traffic,
// all checked against a queue-based reference model of arbitration and routing.
module tb_bp_me_cache_pkt_arbiter;
  localparam int N   = 2;
  localparam int PW  = 118;
  localparam int DW  = 64;
  localparam int ELS = 4;
  localparam int VW  = N + 1 + PW + N + DW + 1 + 1;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N*PW-1:0]   pkt_i;
  logic [N-1:0]      pkt_v_i;
  logic [N-1:0]      pkt_lock_i;
  logic [N-1:0]      pkt_yumi_o;
  logic [DW-1:0]     data_o;
  logic [N-1:0]      data_v_o;
  logic [N-1:0]      data_yumi_i;
  logic [PW-1:0]     cache_pkt_o;
  logic              cache_pkt_v_o;
  logic              cache_pkt_ready_i;
  logic [DW-1:0]     cache_data_i;
  logic              cache_v_i;
  logic              cache_yumi_o;
  logic              err_o;

  bp_me_cache_pkt_arbiter #(
    .num_req_p(N), .pkt_width_p(PW), .data_width_p(DW), .els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pkt_i(pkt_i), .pkt_v_i(pkt_v_i),
    .pkt_lock_i(pkt_lock_i), .pkt_yumi_o(pkt_yumi_o), .data_o(data_o),
    .data_v_o(data_v_o), .data_yumi_i(data_yumi_i), .cache_pkt_o(cache_pkt_o),
    .cache_pkt_v_o(cache_pkt_v_o), .cache_pkt_ready_i(cache_pkt_ready_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i),
    .cache_yumi_o(cache_yumi_o), .err_o(err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_rr;
  int         m_owner;
  bit         m_locked;
  bit         m_err;
  logic [7:0] exp_q[$];
  bit         auto_drain;

  logic [VW-1:0] exp_vec, obs_vec;
  logic [N-1:0]  obs_yumi, obs_dv;
  logic [DW-1:0] obs_data;
  logic          obs_cpv, obs_cy, obs_err;

  task automatic apply_reset();
    reset_i = 1'b1;
    pkt_v_i = '0; pkt_lock_i = '0; data_yumi_i = '0;
    cache_v_i = 1'b0; cache_pkt_ready_i = 1'b1; cache_data_i = '0; pkt_i = '0;
    auto_drain = 1'b0;
    m_rr = 0; m_owner = 0; m_locked = 1'b0; m_err = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  // One clock: randomise packet payloads, predict outputs, sample DUT, advance model.
  task automatic drive_cycle();
    int g;
    int head;
    bit pop;
    logic [127:0] t;
    logic [N-1:0]  e_yumi, e_dv;
    logic [PW-1:0] e_pkt;
    for (int r = 0; r < N; r++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      pkt_i[r*PW +: PW] = t[PW-1:0];
    end
    if (auto_drain) cache_v_i = (exp_q.size() > 0);
    #2;
    g = -1;
    if (cache_pkt_ready_i && exp_q.size() < ELS) begin
      if (m_locked) begin
        if (pkt_v_i[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          int r;
          r = (m_rr + k) % N;
          if (g < 0 && pkt_v_i[r]) g = r;
        end
      end
    end
    e_yumi = '0; e_pkt = '0; e_dv = '0; pop = 1'b0;
    if (g >= 0) begin
      e_yumi[g] = 1'b1;
      e_pkt = pkt_i[g*PW +: PW];
    end
    if (cache_v_i && exp_q.size() > 0) begin
      head = int'(exp_q[0]);
      e_dv[head] = 1'b1;
      pop = data_yumi_i[head];
    end
    exp_vec = {e_yumi, (g >= 0), e_pkt, e_dv, cache_data_i, pop, m_err};
    obs_vec = {pkt_yumi_o, cache_pkt_v_o, cache_pkt_o, data_v_o, data_o, cache_yumi_o, err_o};
    obs_yumi = pkt_yumi_o; obs_dv = data_v_o; obs_data = data_o;
    obs_cpv = cache_pkt_v_o; obs_cy = cache_yumi_o; obs_err = err_o;
    @(posedge clk_i);
    if (cache_v_i && exp_q.size() == 0) m_err = 1'b1;
    if (pop) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back(8'(g));
      m_rr = (g + 1) % N;
      m_locked = pkt_lock_i[g];
      m_owner = g;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    pkt_v_i = 2'b11; pkt_lock_i = 2'b11; data_yumi_i = 2'b11;
    cache_pkt_ready_i = 1'b1; cache_v_i = 1'b1;
    cache_data_i = {$urandom, $urandom};
    pkt_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1;
    obs_vec = {pkt_yumi_o, cache_pkt_v_o, cache_pkt_o, data_v_o, data_o, cache_yumi_o, err_o};
    checks++;
    if (obs_vec !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obs_vec);
    end
    apply_reset();
  endtask

  task automatic test_single_req();
    logic [1:0]  pv [11] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic        cv [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [3:0]  dd [11] = '{0, 0, 0, 4'hA, 4'hB, 4'hC, 0, 0, 0, 0, 0};
    logic [1:0]  wy [11] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [1:0]  wd [11] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [DW-1:0] want_data;
    apply_reset();
    data_yumi_i = 2'b01;
    for (int i = 0; i < 11; i++) begin
      pkt_v_i = pv[i]; cache_v_i = cv[i]; cache_data_i = DW'(dd[i]);
      want_data = DW'(dd[i]);
      drive_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL single_model cyc %0d: got %h want %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (obs_yumi !== wy[i] || obs_dv !== wd[i] || obs_data !== want_data) begin
        errors++;
        $display("FAIL single_seq cyc %0d: yumi %b dv %b data %h want %b %b %h",
                 i, obs_yumi, obs_dv, obs_data, wy[i], wd[i], want_data);
      end
    end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 0, 1, 0, 1};
    logic [N-1:0] want;
    apply_reset();
    auto_drain = 1'b1; data_yumi_i = 2'b11;
    for (int i = 0; i < 7; i++) begin
      pkt_v_i = (i < 6) ? 2'b11 : 2'b00;
      cache_data_i = {$urandom, $urandom};
      drive_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rr_model cyc %0d: got %h want %h", i, obs_vec, exp_vec);
      end
      want = '0;
      if (i < 6) want[order[i]] = 1'b1;
      checks++;
      if (obs_yumi !== want) begin
        errors++;
        $display("FAIL rr_grant cyc %0d: got %b want %b", i, obs_yumi, want);
      end
      want = '0;
      if (i > 0) want[order[i-1]] = 1'b1;
      checks++;
      if (obs_dv !== want) begin
        errors++;
        $display("FAIL rr_route cyc %0d: got %b want %b", i, obs_dv, want);
      end
    end
  endtask

  task automatic test_lock();
    logic [1:0] pv [10] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [1:0] lk [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [1:0] wy [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    apply_reset();
    auto_drain = 1'b1; data_yumi_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      pkt_v_i = pv[i]; pkt_lock_i = lk[i];
      cache_data_i = {$urandom, $urandom};
      drive_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL lock_model cyc %0d: got %h want %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (obs_yumi !== wy[i]) begin
        errors++;
        $display("FAIL lock_grant cyc %0d: got %b want %b", i, obs_yumi, wy[i]);
      end
    end
  endtask

  task automatic test_full();
    logic       cv [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [1:0] wy [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    logic       wc [7] = '{0, 0, 0, 0, 0, 1, 0};
    apply_reset();
    pkt_v_i = 2'b01; data_yumi_i = 2'b01;
    for (int i = 0; i < 7; i++) begin
      cache_v_i = cv[i];
      cache_data_i = {$urandom, $urandom};
      drive_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL full_model cyc %0d: got %h want %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (obs_yumi !== wy[i] || obs_cy !== wc[i]) begin
        errors++;
        $display("FAIL full_seq cyc %0d: yumi %b cyumi %b want %b %b", i, obs_yumi, obs_cy, wy[i], wc[i]);
      end
    end
  endtask

  task automatic test_not_ready();
    logic [1:0] pv [5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       rd [5] = '{1, 0, 0, 0, 1};
    logic [1:0] wy [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      pkt_v_i = pv[i]; cache_pkt_ready_i = rd[i];
      drive_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL notready_model cyc %0d: got %h want %h", i, obs_vec, exp_vec);
      end
      checks++;
      if (obs_yumi !== wy[i] || obs_cpv !== (|wy[i])) begin
        errors++;
        $display("FAIL notready_seq cyc %0d: yumi %b cpv %b want %b %b", i, obs_yumi, obs_cpv, wy[i], |wy[i]);
      end
    end
  endtask

  task automatic test_err_async_reset();
    apply_reset();
    cache_v_i = 1'b1; data_yumi_i = 2'b11;
    drive_cycle();
    checks++;
    if (obs_dv !== 2'b00 || obs_cy !== 1'b0 || obs_err !== 1'b0 || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL err_orphan: dv %b cyumi %b err %b vec %h want %h", obs_dv, obs_cy, obs_err, obs_vec, exp_vec);
    end
    cache_v_i = 1'b0; pkt_v_i = 2'b10; pkt_lock_i = 2'b10;
    drive_cycle();
    checks++;
    if (obs_err !== 1'b1 || obs_yumi !== 2'b10 || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL err_sticky_lock: err %b yumi %b want 1 10", obs_err, obs_yumi);
    end
    pkt_v_i = 2'b11; cache_v_i = 1'b1; data_yumi_i = 2'b00;
    cache_data_i = {$urandom, $urandom};
    #1 reset_i = 1'b1;
    #1;
    obs_vec = {pkt_yumi_o, cache_pkt_v_o, cache_pkt_o, data_v_o, data_o, cache_yumi_o, err_o};
    checks++;
    if (obs_vec !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h want 0", obs_vec);
    end
    apply_reset();
    pkt_v_i = 2'b11;
    drive_cycle();
    checks++;
    if (obs_yumi !== 2'b01 || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_clears_lock: yumi %b want 01", obs_yumi);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      pkt_v_i = N'($urandom_range(0, 3));
      pkt_lock_i = ($urandom_range(0, 3) == 0) ? 2'b00 : N'($urandom_range(0, 3));
      cache_pkt_ready_i = ($urandom_range(0, 3) != 0);
      cache_v_i = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      data_yumi_i = N'($urandom_range(0, 3));
      cache_data_i = {$urandom, $urandom};
      drive_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_model cyc %0d: got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_lock();
    test_full();
    test_not_ready();
    test_random();
    test_err_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
